// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared constants and scoreboard entry type for the hazard
//               scoreboard (forwarding-select encodings, PC register index).
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Forwarding-select encodings: 0 = register file, k = downstream stage k
    localparam int FWD_RF  = 0;
    localparam int FWD_EX  = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB  = 3;

    // R15 is the PC and is never forwarded
    localparam int PC_REG  = 15;

    // Widest register index the entry type can hold; narrower indices are
    // zero-extended into the dst field so one typedef serves every REG_W.
    localparam int DST_W_MAX = 8;

    // One in-flight register write tracked in the shadow pipeline
    typedef struct packed {
        logic                 valid;
        logic [DST_W_MAX-1:0] dst;
        logic                 wr_en;
        logic                 is_load;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : ID-stage bundle between the control unit / operand muxes and
//               the hazard scoreboard.
//               master : ID-stage side (drives instruction info, branch_taken)
//               slave  : scoreboard side (drives forwarding / stall controls)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int NUM_SRC    = 3,
    parameter int REG_W      = 4,
    parameter int FWD_STAGES = 3,
    parameter int CNT_W      = 16
);
    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    // ID-stage instruction information
    logic                       id_valid;
    logic [NUM_SRC*REG_W-1:0]   id_src;
    logic [NUM_SRC-1:0]         id_src_used;
    logic [REG_W-1:0]           id_dst;
    logic                       id_wr_en;
    logic                       id_is_load;
    logic                       branch_taken;

    // Scoreboard controls
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic                       stall;
    logic                       pc_enable;
    logic                       ifid_le;
    logic                       nop_insert;
    logic                       flush_ifid;
    logic [CNT_W-1:0]           stall_count;
    logic [CNT_W-1:0]           flush_count;

    modport master (
        output id_valid, id_src, id_src_used, id_dst, id_wr_en, id_is_load,
               branch_taken,
        input  fwd_sel, stall, pc_enable, ifid_le, nop_insert, flush_ifid,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_dst, id_wr_en, id_is_load,
               branch_taken,
        output fwd_sel, stall, pc_enable, ifid_le, nop_insert, flush_ifid,
               stall_count, flush_count
    );

endinterface
`default_nettype wire

// File: rtl/hazard_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_match
// Description : Priority compare of one source register against the tracked
//               in-flight writes. The youngest (smallest stage index) match
//               wins. A load matched at stage <= LOAD_LAT is not yet
//               forwardable and raises o_load_blocked.
// Ports       : i_src          - source register index
//               i_used         - source is actually read
//               i_entries      - tracked entries, stage 1..FWD_STAGES
//               o_sel          - 0 = register file, k = forward from stage k
//               o_load_blocked - winning match is a load still in flight
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 2
) (
    input  wire logic [REG_W-1:0]            i_src,
    input  wire logic                        i_used,
    input  wire sb_entry_t [FWD_STAGES:1]    i_entries,
    output logic      [SEL_W-1:0]            o_sel,
    output logic                             o_load_blocked
);

    logic [DST_W_MAX-1:0] w_src_ext;
    assign w_src_ext = DST_W_MAX'(i_src);

    always_comb begin
        o_sel          = SEL_W'(FWD_RF);
        o_load_blocked = 1'b0;
        if (i_used && (i_src != REG_W'(PC_REG))) begin
            // Walk oldest to youngest so the youngest match overwrites.
            // The select still reports the matching stage when blocked so
            // the operand mux sees a deterministic value during a stall.
            for (int k = FWD_STAGES; k >= FWD_EX; k--) begin
                if (i_entries[k].valid && i_entries[k].wr_en &&
                    (i_entries[k].dst == w_src_ext)) begin
                    o_sel          = SEL_W'(k);
                    o_load_blocked = i_entries[k].is_load && (k <= LOAD_LAT);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Hazard detection and forwarding unit for the ID stage.
//               A shadow shift register mirrors ID/EX, EX/MEM, MEM/WB (up to
//               FWD_STAGES deep) and records in-flight register writes.
//               Produces per-source forwarding selects, load-use stalls and
//               IF/ID, ID/EX bubble/flush controls.
// Ports       : CLK  - clock
//               CLR  - synchronous active-high reset
//               bus  - hazard_scoreboard_if.slave (ID info in, controls out)
// Config      : HAZARD_STATS_EN - when defined, builds saturating stall and
//               flush counters; otherwise stall_count/flush_count read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int REG_W      = 4,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  wire logic           CLK,
    input  wire logic           CLR,
    hazard_scoreboard_if.slave  bus
);

    localparam int SEL_W = $clog2(FWD_STAGES + 1);

    sb_entry_t [FWD_STAGES:1]   r_entry_q;
    sb_entry_t [FWD_STAGES:1]   w_entry_d;
    logic [NUM_SRC-1:0]         w_blocked;
    logic [NUM_SRC*SEL_W-1:0]   w_fwd_sel;
    logic                       w_stall;
    logic                       w_accept;

    // ------------------------------------------------------------------
    // Per-source priority match
    // ------------------------------------------------------------------
    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            hazard_fwd_match #(
                .REG_W      (REG_W),
                .FWD_STAGES (FWD_STAGES),
                .LOAD_LAT   (LOAD_LAT),
                .SEL_W      (SEL_W)
            ) u_match (
                .i_src          (bus.id_src[s*REG_W +: REG_W]),
                .i_used         (bus.id_src_used[s]),
                .i_entries      (r_entry_q),
                .o_sel          (w_fwd_sel[s*SEL_W +: SEL_W]),
                .o_load_blocked (w_blocked[s])
            );
        end
    endgenerate

    // A taken branch squashes the ID instruction, so it can never stall.
    assign w_stall  = bus.id_valid && (|w_blocked) && !bus.branch_taken;
    assign w_accept = bus.id_valid && !w_stall && !bus.branch_taken;

    // ------------------------------------------------------------------
    // Shadow pipeline: shifts every cycle; a stalled or squashed ID
    // instruction becomes a bubble in stage 1.
    // ------------------------------------------------------------------
    always_comb begin
        w_entry_d = '0;
        if (w_accept) begin
            w_entry_d[1].valid   = 1'b1;
            w_entry_d[1].dst     = DST_W_MAX'(bus.id_dst);
            w_entry_d[1].wr_en   = bus.id_wr_en;
            w_entry_d[1].is_load = bus.id_is_load;
        end
        for (int k = 2; k <= FWD_STAGES; k++) begin
            w_entry_d[k] = r_entry_q[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_entry_q <= '0;
        end else begin
            r_entry_q <= w_entry_d;
        end
    end

    // ------------------------------------------------------------------
    // Control outputs
    // ------------------------------------------------------------------
    assign bus.fwd_sel    = w_fwd_sel;
    assign bus.stall      = w_stall;
    assign bus.pc_enable  = !w_stall;
    assign bus.ifid_le    = !w_stall;
    assign bus.nop_insert = w_stall || bus.branch_taken;
    assign bus.flush_ifid = bus.branch_taken;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt_q, w_stall_cnt_d;
    logic [CNT_W-1:0] r_flush_cnt_q, w_flush_cnt_d;

    // Counters hold at all-ones rather than wrapping.
    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        w_flush_cnt_d = r_flush_cnt_q;
        if (w_stall && (r_stall_cnt_q != {CNT_W{1'b1}})) begin
            w_stall_cnt_d = r_stall_cnt_q + 1'b1;
        end
        if (bus.branch_taken && (r_flush_cnt_q != {CNT_W{1'b1}})) begin
            w_flush_cnt_d = r_flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
            r_flush_cnt_q <= w_flush_cnt_d;
        end
    end

    assign bus.stall_count = r_stall_cnt_q;
    assign bus.flush_count = r_flush_cnt_q;
`else
    assign bus.stall_count = '0;
    assign bus.flush_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed self-checking bench. Two scoreboards share the same
//               ID stimulus: dut_a with LOAD_LAT = 1 and dut_b with
//               LOAD_LAT = 2. Outputs are checked 2 time units after the
//               rising edge once inputs have settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NS = 3;
    localparam int RW = 4;
    localparam int FS = 3;
    localparam int CW = 16;
    localparam int SW = 2;

    // Control bundle order: {stall, pc_enable, ifid_le, nop_insert, flush_ifid}
    localparam logic [4:0] CTL_RUN   = 5'b01100;
    localparam logic [4:0] CTL_STALL = 5'b10010;
    localparam logic [4:0] CTL_FLUSH = 5'b01111;

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard_if #(.NUM_SRC(NS), .REG_W(RW), .FWD_STAGES(FS), .CNT_W(CW)) ifa ();
    hazard_scoreboard_if #(.NUM_SRC(NS), .REG_W(RW), .FWD_STAGES(FS), .CNT_W(CW)) ifb ();

    hazard_scoreboard #(.NUM_SRC(NS), .REG_W(RW), .FWD_STAGES(FS), .LOAD_LAT(1), .CNT_W(CW))
        dut_a (.CLK(CLK), .CLR(CLR), .bus(ifa.slave));
    hazard_scoreboard #(.NUM_SRC(NS), .REG_W(RW), .FWD_STAGES(FS), .LOAD_LAT(2), .CNT_W(CW))
        dut_b (.CLK(CLK), .CLR(CLR), .bus(ifb.slave));

    // Drive the same ID-stage instruction into both scoreboards
    task automatic drive(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [2:0] used,
                         input logic [3:0] dst, input logic wr, input logic ld,
                         input logic br);
        ifa.id_valid = v;  ifa.id_src = {s2, s1, s0}; ifa.id_src_used = used;
        ifa.id_dst = dst;  ifa.id_wr_en = wr; ifa.id_is_load = ld; ifa.branch_taken = br;
        ifb.id_valid = v;  ifb.id_src = {s2, s1, s0}; ifb.id_src_used = used;
        ifb.id_dst = dst;  ifb.id_wr_en = wr; ifb.id_is_load = ld; ifb.branch_taken = br;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Bubbles flush every tracked stage
    task automatic idle;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (FS) tick();
    endtask

    function automatic logic [SW-1:0] sel_a(input int s);
        return ifa.fwd_sel[s*SW +: SW];
    endfunction

    function automatic logic [SW-1:0] sel_b(input int s);
        return ifb.fwd_sel[s*SW +: SW];
    endfunction

    function automatic logic [4:0] ctl_a();
        return {ifa.stall, ifa.pc_enable, ifa.ifid_le, ifa.nop_insert, ifa.flush_ifid};
    endfunction

    function automatic logic [4:0] ctl_b();
        return {ifb.stall, ifb.pc_enable, ifb.ifid_le, ifb.nop_insert, ifb.flush_ifid};
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset;
        CLR = 1'b1;
        drive(1'b1, 4'd1, 4'd1, 4'd1, 3'b111, 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        CLR = 1'b0;
        drive(1'b1, 4'd1, 4'd1, 4'd1, 3'b111, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (ctl_a() !== CTL_RUN) begin n_err++; $display("FAIL reset_ctl_a got %b exp %b", ctl_a(), CTL_RUN); end
        n_cmp++; if (ctl_b() !== CTL_RUN) begin n_err++; $display("FAIL reset_ctl_b got %b exp %b", ctl_b(), CTL_RUN); end
        n_cmp++; if (ifa.fwd_sel !== 6'd0) begin n_err++; $display("FAIL reset_fwd_sel got %h exp 0", ifa.fwd_sel); end
        n_cmp++; if (ifa.stall_count !== 16'd0 || ifa.flush_count !== 16'd0) begin
            n_err++; $display("FAIL reset_counts got %0d/%0d exp 0/0", ifa.stall_count, ifa.flush_count); end
        tick();
    endtask

    // ADD R1 then consumers of R1 walking through EX, MEM, WB and off the end
    task automatic test_alu_back_to_back;
        idle();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd1, 4'd0, 4'd0, 3'b001, 4'd5, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (sel_a(0) !== 2'd1) begin n_err++; $display("FAIL alu_sel_ex got %0d exp 1", sel_a(0)); end
        n_cmp++; if (ctl_a() !== CTL_RUN) begin n_err++; $display("FAIL alu_ctl got %b exp %b", ctl_a(), CTL_RUN); end
        tick();
        n_cmp++; if (sel_a(0) !== 2'd2) begin n_err++; $display("FAIL alu_sel_mem got %0d exp 2", sel_a(0)); end
        n_cmp++; if (sel_b(0) !== 2'd2) begin n_err++; $display("FAIL alu_sel_mem_b got %0d exp 2", sel_b(0)); end
        tick();
        n_cmp++; if (sel_a(0) !== 2'd3) begin n_err++; $display("FAIL alu_sel_wb got %0d exp 3", sel_a(0)); end
        tick();
        n_cmp++; if (sel_a(0) !== 2'd0) begin n_err++; $display("FAIL alu_sel_gone got %0d exp 0", sel_a(0)); end
    endtask

    // LDR R2 then a consumer in slot 1: 1 stall (LOAD_LAT=1) vs 2 (LOAD_LAT=2)
    task automatic test_load_use;
        idle();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 4'd0, 4'd2, 4'd0, 3'b010, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (ctl_a() !== CTL_STALL) begin n_err++; $display("FAIL lu_ctl_a_c1 got %b exp %b", ctl_a(), CTL_STALL); end
        n_cmp++; if (ctl_b() !== CTL_STALL) begin n_err++; $display("FAIL lu_ctl_b_c1 got %b exp %b", ctl_b(), CTL_STALL); end
        n_cmp++; if (sel_a(1) !== 2'd1) begin n_err++; $display("FAIL lu_sel_blocked got %0d exp 1", sel_a(1)); end
        tick();
        n_cmp++; if (ctl_a() !== CTL_RUN) begin n_err++; $display("FAIL lu_ctl_a_c2 got %b exp %b", ctl_a(), CTL_RUN); end
        n_cmp++; if (sel_a(1) !== 2'd2) begin n_err++; $display("FAIL lu_sel_a_c2 got %0d exp 2", sel_a(1)); end
        n_cmp++; if (ctl_b() !== CTL_STALL) begin n_err++; $display("FAIL lu_ctl_b_c2 got %b exp %b", ctl_b(), CTL_STALL); end
        tick();
        n_cmp++; if (ctl_b() !== CTL_RUN) begin n_err++; $display("FAIL lu_ctl_b_c3 got %b exp %b", ctl_b(), CTL_RUN); end
        n_cmp++; if (sel_b(1) !== 2'd3) begin n_err++; $display("FAIL lu_sel_b_c3 got %0d exp 3", sel_b(1)); end
    endtask

    // R3 written at stages 3 and 1, R7 at stage 2
    task automatic test_priority;
        idle();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd7, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 4'd7, 4'd0, 4'd3, 3'b101, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (sel_a(2) !== 2'd1) begin n_err++; $display("FAIL prio_youngest got %0d exp 1", sel_a(2)); end
        n_cmp++; if (sel_a(0) !== 2'd2) begin n_err++; $display("FAIL prio_r7 got %0d exp 2", sel_a(0)); end
        n_cmp++; if (sel_a(1) !== 2'd0) begin n_err++; $display("FAIL prio_unused_r0 got %0d exp 0", sel_a(1)); end
    endtask

    // e1 = R4 (no write), e2 = R15, e3 = R6
    task automatic test_non_forwarding;
        idle();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd6,  1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd15, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd4,  1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 4'd15, 4'd4, 4'd6, 3'b011, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (sel_a(0) !== 2'd0) begin n_err++; $display("FAIL nf_pc got %0d exp 0", sel_a(0)); end
        n_cmp++; if (sel_a(1) !== 2'd0) begin n_err++; $display("FAIL nf_no_wr got %0d exp 0", sel_a(1)); end
        n_cmp++; if (sel_a(2) !== 2'd0) begin n_err++; $display("FAIL nf_unused got %0d exp 0", sel_a(2)); end
        drive(1'b1, 4'd15, 4'd4, 4'd6, 3'b111, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (sel_a(2) !== 2'd3) begin n_err++; $display("FAIL nf_used_r6 got %0d exp 3", sel_a(2)); end
    endtask

    // Branch in the same cycle as a load-use match; squashed dst R10
    task automatic test_flush_beats_stall;
        idle();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd9, 1'b1, 1'b1, 1'b0); tick();
        drive(1'b1, 4'd9, 4'd0, 4'd0, 3'b001, 4'd10, 1'b1, 1'b0, 1'b1);
        #1;
        n_cmp++; if (ctl_a() !== CTL_FLUSH) begin n_err++; $display("FAIL fl_ctl_a got %b exp %b", ctl_a(), CTL_FLUSH); end
        n_cmp++; if (ctl_b() !== CTL_FLUSH) begin n_err++; $display("FAIL fl_ctl_b got %b exp %b", ctl_b(), CTL_FLUSH); end
        tick();
        drive(1'b1, 4'd10, 4'd9, 4'd0, 3'b011, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        n_cmp++; if (sel_a(0) !== 2'd0) begin n_err++; $display("FAIL fl_squashed got %0d exp 0", sel_a(0)); end
        n_cmp++; if (ctl_a() !== CTL_RUN) begin n_err++; $display("FAIL fl_ctl_a_after got %b exp %b", ctl_a(), CTL_RUN); end
        n_cmp++; if (sel_a(1) !== 2'd2) begin n_err++; $display("FAIL fl_load_mem got %0d exp 2", sel_a(1)); end
        n_cmp++; if (ctl_b() !== CTL_STALL) begin n_err++; $display("FAIL fl_ctl_b_after got %b exp %b", ctl_b(), CTL_STALL); end
    endtask

    // Three load/use pairs back to back, two flushes, then CLR mid-operation
    task automatic test_back_to_back_stats;
        int exp_sa, exp_sb, exp_f;
`ifdef HAZARD_STATS_EN
        exp_sa = 3; exp_sb = 6; exp_f = 2;
`else
        exp_sa = 0; exp_sb = 0; exp_f = 0;
`endif
        CLR = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        CLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b1, 1'b0); tick();
            drive(1'b1, 4'd2, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0); tick();
            tick();
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b1); tick(); tick();
        drive(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 4'd8, 1'b1, 1'b0, 1'b0);
        #1;
        n_cmp++; if (ifa.stall_count !== CW'(exp_sa)) begin n_err++; $display("FAIL st_stall_a got %0d exp %0d", ifa.stall_count, exp_sa); end
        n_cmp++; if (ifb.stall_count !== CW'(exp_sb)) begin n_err++; $display("FAIL st_stall_b got %0d exp %0d", ifb.stall_count, exp_sb); end
        n_cmp++; if (ifa.flush_count !== CW'(exp_f)) begin n_err++; $display("FAIL st_flush_a got %0d exp %0d", ifa.flush_count, exp_f); end
        tick();
        CLR = 1'b1;
        drive(1'b1, 4'd8, 4'd0, 4'd0, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        CLR = 1'b0;
        #1;
        n_cmp++; if (sel_a(0) !== 2'd0) begin n_err++; $display("FAIL clr_no_fwd got %0d exp 0", sel_a(0)); end
        n_cmp++; if (ifa.stall_count !== 16'd0 || ifa.flush_count !== 16'd0) begin
            n_err++; $display("FAIL clr_counts got %0d/%0d exp 0/0", ifa.stall_count, ifa.flush_count); end
    endtask

    initial begin
        drive(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_alu_back_to_back();
        test_load_use();
        test_priority();
        test_non_forwarding();
        test_flush_beats_stall();
        test_back_to_back_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
